// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: multi-cycle mult/div into HI/LO,
// single-cycle mthi/mtlo, combinational mfhi/mflo and D-stage stall request.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             d_is_md,
    output logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] md_rdata,
    output logic             md_stall
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic               res_we_q, res_we_d;

    // Products: sign- or zero-extend to 2*WIDTH so the low 2*WIDTH bits are exact.
    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
    assign a_sx   = {{WIDTH{src_a[WIDTH-1]}}, src_a};
    assign b_sx   = {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign a_zx   = {{WIDTH{1'b0}}, src_a};
    assign b_zx   = {{WIDTH{1'b0}}, src_b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    // Signed division on magnitudes; MIN / -1 falls out as quotient MIN, remainder 0.
    logic             b_zero, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, b_safe, b_mag_safe;
    logic [WIDTH-1:0] qs_mag, rs_mag, q_s, r_s, q_u, r_u;
    assign b_zero     = (src_b == '0);
    assign a_neg      = src_a[WIDTH-1];
    assign b_neg      = src_b[WIDTH-1];
    assign a_mag      = a_neg ? (~src_a + 1'b1) : src_a;
    assign b_mag      = b_neg ? (~src_b + 1'b1) : src_b;
    assign b_safe     = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : src_b;
    assign b_mag_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    assign qs_mag     = a_mag / b_mag_safe;
    assign rs_mag     = a_mag % b_mag_safe;
    assign q_s        = (a_neg ^ b_neg) ? (~qs_mag + 1'b1) : qs_mag;
    assign r_s        = a_neg ? (~rs_mag + 1'b1) : rs_mag;
    assign q_u        = src_a / b_safe;
    assign r_u        = src_a % b_safe;

    assign busy     = (state_q == S_RUN);
    assign start    = (state_q == S_IDLE) && (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign md_stall = d_is_md & (start | busy);
    assign hi       = hi_q;
    assign lo       = lo_q;

    always_comb begin
        md_rdata = '0;
        if (md_op == OP_MFHI) md_rdata = hi_q;
        else if (md_op == OP_MFLO) md_rdata = lo_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_we_d = res_we_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    res_we_d = 1'b1;
                    unique case (md_op)
                        OP_MULT: begin
                            {res_hi_d, res_lo_d} = prod_s;
                            cnt_d = CNT_W'(MULT_CYCLES);
                        end
                        OP_MULTU: begin
                            {res_hi_d, res_lo_d} = prod_u;
                            cnt_d = CNT_W'(MULT_CYCLES);
                        end
                        OP_DIV: begin
                            res_hi_d = r_s;
                            res_lo_d = q_s;
                            res_we_d = ~b_zero;
                            cnt_d    = CNT_W'(DIV_CYCLES);
                        end
                        default: begin
                            res_hi_d = r_u;
                            res_lo_d = q_u;
                            res_we_d = ~b_zero;
                            cnt_d    = CNT_W'(DIV_CYCLES);
                        end
                    endcase
                end else if (md_op == OP_MTHI) begin
                    hi_d = src_a;
                end else if (md_op == OP_MTLO) begin
                    lo_d = src_a;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    // Divide by zero leaves HI/LO untouched once latency elapses.
                    if (res_we_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_we_q <= res_we_d;
        end
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit for the pipelined MIPS core; sits in the E stage beside the ALU.
- Executes mult/multu/div/divu over a configurable number of cycles into HI/LO.
- Serves mfhi/mflo/mthi/mtlo.
- Generates the stall request the hazard logic uses to hold D-stage MD instructions while the unit is occupied.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- md_op  in  4  E-stage MD operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; others treated as NONE
- src_a  in  WIDTH  forwarded rs value
- src_b  in  WIDTH  forwarded rt value
- d_is_md  in  1  D-stage instruction is any MD op (1..8)
- start  out  1  combinational; md_op in {1..4} and unit idle
- busy  out  1  registered; multi-cycle operation in progress
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- md_rdata  out  WIDTH  combinational; hi when md_op=MFHI, lo when md_op=MFLO, else 0
- md_stall  out  1  combinational; d_is_md & (start | busy)

Behaviour:
Reset:
- Asynchronous, active-low.
- hi=0, lo=0, busy=0, state=IDLE, counter=0.
- Internal result registers cleared.
- Reset mid-operation aborts the operation; HI/LO stay 0 after release.

FSM states:
- IDLE:
  - On start, latch src_a/src_b and the op, compute the full result into internal registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy rises next edge.
- RUN:
  - Counter decrements each cycle.
  - When counter reaches 1, write the result to HI/LO on that edge, clear busy, return to IDLE.

Timing:
- With start sampled at edge t, busy=1 for cycles t+1 .. t+N (N = latency).
- New HI/LO are visible, and busy=0, from cycle t+N+1.

Operations and arithmetic:
- mult: signed 2*WIDTH product; HI = upper half, LO = lower half.
- multu: unsigned 2*WIDTH product; same split as mult.
- div: LO = quotient truncated toward zero; HI = remainder, sign of dividend.
- div overflow (MIN / -1): LO = MIN, HI = 0.
- divu: unsigned; LO = quotient, HI = remainder.
- Divide by zero (div or divu): latency still elapses; HI/LO unchanged at completion.
- mthi / mtlo: write src_a to hi / lo at the next edge, single cycle, only when idle.
- mfhi / mflo: purely combinational read; no state change.

Boundary conditions:
- Any md_op other than NONE arriving while busy=1 is ignored (hazard unit guarantees it does not occur; unit must not corrupt state).
- mthi/mtlo issued while busy is ignored.
- An md_op in the cycle busy falls is accepted normally.
- mfhi in that same cycle returns the new value.
- start while the previous result completes on the same edge cannot occur: busy is still 1 on that edge, so start=0.
- md_stall depends only on busy, start and d_is_md; non-MD D-stage instructions never stall.

Test Plan:
- Reset low 3 cycles, then release → hi=lo=0, busy=0. Issue MULT src_a=3, src_b=FFFFFFFE → busy high exactly 5 cycles; then hi=FFFFFFFF, lo=FFFFFFFA.
- DIV src_a=FFFFFFF9 (-7), src_b=2 → busy 10 cycles; lo=FFFFFFFD, hi=FFFFFFFF. DIVU same operands → lo=7FFFFFFC, hi=1.
- MTHI 12345678, then MTLO 9ABCDEF0, then MFHI/MFLO → md_rdata = 12345678 then 9ABCDEF0. DIVU by 0 after that → busy 10 cycles; hi/lo unchanged.
- MULTU FFFFFFFF*FFFFFFFF with d_is_md=1 held → md_stall=1 in the start cycle and all 5 busy cycles, 0 afterwards; hi=FFFFFFFE, lo=00000001. DIV 80000000 / FFFFFFFF → lo=80000000, hi=0.
- MULT started, then a second MULT and an MTLO driven while busy → ignored; final hi/lo reflect only the first MULT.
- MULT started, rst_n pulsed low at busy cycle 3 → busy=0 immediately, hi=lo=0, and both stay 0 after release.
